// File: rtl/fc_output_layer.sv
// ---------------------------------------------------------------------------
// fc_output_layer
//   Final fully-connected layer of the classifier. The block computes LAYER_SZ
//   neuron outputs from IN_SZ signed Q8.8 activations and performs one
//   multiply-accumulate per cycle. Weights and biases stream from an external
//   synchronous memory. The packed result stays stable for the downstream
//   softmax/argmax stage while valid is high.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       request computation (only honoured in IDLE or DONE)
//   in_values   IN_SZ packed signed Q8.8 inputs, element 0 in the MS slice
//   w_en        weight memory read enable
//   w_addr      weight memory read address
//   w_data      weight/bias word, valid the cycle after w_en/w_addr
//   out_values  LAYER_SZ packed signed Q8.8 results, neuron 0 in the MS slice
//   valid       out_values complete and stable
//   busy        computation in progress
//
// Memory map: neuron n reads weight i from n*(IN_SZ+1)+i and its bias from
// n*(IN_SZ+1)+IN_SZ. All addresses are read linearly, 0..N-1.
// ---------------------------------------------------------------------------
module fc_output_layer #(
  parameter int SIZE     = 16,
  parameter int IN_SZ    = 4,
  parameter int LAYER_SZ = 2,
  parameter int ADDR_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [IN_SZ*SIZE-1:0]    in_values,
  output logic                     w_en,
  output logic [ADDR_W-1:0]        w_addr,
  input  logic [SIZE-1:0]          w_data,
  output logic [LAYER_SZ*SIZE-1:0] out_values,
  output logic                     valid,
  output logic                     busy
);

  localparam int FRAC    = 8;
  localparam int ACC_W   = 2*SIZE + $clog2(IN_SZ+1) + 1;
  localparam int N_WORDS = LAYER_SZ*(IN_SZ+1);
  localparam int IW      = (IN_SZ > 0) ? $clog2(IN_SZ+1) : 1;
  localparam int NW      = (LAYER_SZ > 1) ? $clog2(LAYER_SZ) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS-1);
  localparam logic [IW-1:0]     BIAS_IDX  = IW'(IN_SZ);
  localparam logic [NW-1:0]     LAST_NEU  = NW'(LAYER_SZ-1);

  // Signed SIZE-bit limits, held at accumulator width for the comparisons
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (SIZE-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state_r;
  logic [IN_SZ*SIZE-1:0]     in_lat_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic [IW-1:0]             in_idx_r;   // position of the datum on w_data within its neuron
  logic [NW-1:0]             neu_idx_r;  // neuron that owns the datum on w_data
  logic [NW-1:0]             wr_neu_r;   // neuron whose slice is written this cycle
  logic                      rd_vld_r;   // w_data carries a requested word
  logic                      wr_pend_r;  // acc_r holds a finished neuron sum

  logic signed [SIZE-1:0]    cur_in_s;
  logic signed [2*SIZE-1:0]  prod_s;
  logic signed [ACC_W-1:0]   term_s;
  logic signed [ACC_W-1:0]   acc_base_s;

  // Drop the fractional bits (floor) and clamp to signed SIZE-bit range.
  function automatic logic [SIZE-1:0] sat_q(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    r = a >>> FRAC;
    if (r > SAT_MAX) begin
      sat_q = SAT_MAX[SIZE-1:0];
    end else if (r < SAT_MIN) begin
      sat_q = SAT_MIN[SIZE-1:0];
    end else begin
      sat_q = r[SIZE-1:0];
    end
  endfunction

  // Select the latched activation that pairs with the weight now on w_data
  always_comb begin
    cur_in_s = '0;
    for (int k = 0; k < IN_SZ; k++) begin
      cur_in_s = (k == int'(in_idx_r)) ? in_lat_r[(IN_SZ-1-k)*SIZE +: SIZE] : cur_in_s;
    end
  end

  // Form the accumulator increment: full Q16.16 product, or bias aligned to Q16.16
  always_comb begin
    prod_s = cur_in_s * $signed(w_data);
    if (in_idx_r == BIAS_IDX) begin
      term_s = {{(ACC_W-SIZE-FRAC){w_data[SIZE-1]}}, w_data, {FRAC{1'b0}}};
    end else begin
      term_s = {{(ACC_W-2*SIZE){prod_s[2*SIZE-1]}}, prod_s};
    end
    // A finished sum is read out this cycle, so the next neuron starts from zero
    acc_base_s = wr_pend_r ? '0 : acc_r;
  end

  // Control FSM, read-address sequencer, accumulator and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      w_en       <= 1'b0;
      w_addr     <= '0;
      out_values <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      in_lat_r   <= '0;
      acc_r      <= '0;
      in_idx_r   <= '0;
      neu_idx_r  <= '0;
      wr_neu_r   <= '0;
      rd_vld_r   <= 1'b0;
      wr_pend_r  <= 1'b0;
    end else begin
      // Memory returns data one cycle after the request
      rd_vld_r  <= w_en;
      wr_pend_r <= 1'b0;

      if (wr_pend_r) begin
        for (int k = 0; k < LAYER_SZ; k++) begin
          if (k == int'(wr_neu_r)) begin
            out_values[(LAYER_SZ-1-k)*SIZE +: SIZE] <= sat_q(acc_r);
          end
        end
      end

      if (rd_vld_r) begin
        acc_r <= acc_base_s + term_s;
        if (in_idx_r == BIAS_IDX) begin
          in_idx_r  <= '0;
          wr_pend_r <= 1'b1;
          wr_neu_r  <= neu_idx_r;
          neu_idx_r <= (neu_idx_r == LAST_NEU) ? '0 : neu_idx_r + 1'b1;
        end else begin
          in_idx_r <= in_idx_r + 1'b1;
        end
      end else begin
        acc_r <= acc_base_s;
      end

      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            in_lat_r  <= in_values;
            w_en      <= 1'b1;
            w_addr    <= '0;
            busy      <= 1'b1;
            valid     <= 1'b0;
            acc_r     <= '0;
            in_idx_r  <= '0;
            neu_idx_r <= '0;
            state_r   <= RUN;
          end
        end
        RUN: begin
          if (w_addr == LAST_ADDR) begin
            w_en    <= 1'b0;
            state_r <= DRAIN;
          end else begin
            w_addr <= w_addr + 1'b1;
          end
        end
        DRAIN: begin
          // The last neuron's slice is written on this edge
          if (wr_pend_r && (wr_neu_r == LAST_NEU)) begin
            valid   <= 1'b1;
            busy    <= 1'b0;
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_output_layer.sv
// Directed bench for fc_output_layer (IN_SZ=2, LAYER_SZ=2 -> N=6 words).
// A small synchronous memory model serves w_data. Each operation checks the
// per-cycle handshake (busy, valid, w_en, w_addr) and the final result.
module tb_fc_output_layer;

  localparam int SIZE     = 16;
  localparam int IN_SZ    = 2;
  localparam int LAYER_SZ = 2;
  localparam int ADDR_W   = 8;
  localparam int N        = LAYER_SZ*(IN_SZ+1);

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic [IN_SZ*SIZE-1:0]    in_values;
  logic                     w_en;
  logic [ADDR_W-1:0]        w_addr;
  logic [SIZE-1:0]          w_data;
  logic [LAYER_SZ*SIZE-1:0] out_values;
  logic                     valid;
  logic                     busy;

  logic [SIZE-1:0] mem [0:N-1];

  int n_checks = 0;
  int n_errors = 0;

  fc_output_layer #(
    .SIZE(SIZE), .IN_SZ(IN_SZ), .LAYER_SZ(LAYER_SZ), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_values(in_values),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .out_values(out_values), .valid(valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous weight memory: data appears the cycle after the request
  always @(posedge clk) begin
    if (w_en) w_data <= mem[int'(w_addr)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem(input logic [SIZE-1:0] m0, m1, m2, m3, m4, m5);
    mem[0] = m0; mem[1] = m1; mem[2] = m2;
    mem[3] = m3; mem[4] = m4; mem[5] = m5;
  endtask

  // Accept at edge 0, re-pulse start on edges 3 and 5, swap inputs after accept,
  // optionally assert reset at edge rst_at (then stop early).
  task automatic run_op(input string tag, input logic [31:0] inv, input logic [31:0] alt_in,
                        input logic [31:0] exp_out, input int rst_at);
    in_values = inv;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_valid"}, 32'(valid), 32'd0);
    chk({tag, "_acc_wen"}, 32'(w_en), 32'd1);
    chk({tag, "_acc_addr"}, 32'(w_addr), 32'd0);
    for (int k = 1; k <= N+2; k++) begin
      start = ((k == 3) || (k == 5)) ? 1'b1 : 1'b0;
      if (k == 2) in_values = alt_in;
      if (k == rst_at) rst_n = 1'b0;
      tick();
      start = 1'b0;
      if (k == rst_at) begin
        chk({tag, "_rst_valid"}, 32'(valid), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_wen"}, 32'(w_en), 32'd0);
        chk({tag, "_rst_out"}, 32'(out_values), 32'd0);
        rst_n = 1'b1;
        tick();
        return;
      end
      chk($sformatf("%s_busy_e%0d", tag, k), 32'(busy), (k <= N+1) ? 32'd1 : 32'd0);
      chk($sformatf("%s_valid_e%0d", tag, k), 32'(valid), (k == N+2) ? 32'd1 : 32'd0);
      chk($sformatf("%s_wen_e%0d", tag, k), 32'(w_en), (k <= N-1) ? 32'd1 : 32'd0);
      if (k <= N-1) chk($sformatf("%s_addr_e%0d", tag, k), 32'(w_addr), 32'(k));
    end
    chk({tag, "_out"}, 32'(out_values), exp_out);
  endtask

  initial begin
    logic [31:0] cls;
    rst_n     = 1'b0;
    start     = 1'b0;
    in_values = '0;
    w_data    = '0;
    load_mem(16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'hFF00, 16'h0100);
    tick();
    tick();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_out", 32'(out_values), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic: {1.0, 2.0} -> {3.0, -0.5}
    run_op("basic", 32'h0100_0200, 32'h0100_0200, 32'h0300_FF80, 0);
    cls = ($signed(out_values[31:16]) >= $signed(out_values[15:0])) ? 32'd0 : 32'd1;
    chk("basic_class", cls, 32'd0);
    tick(); tick(); tick();
    chk("done_hold_valid", 32'(valid), 32'd1);
    chk("done_hold_out", 32'(out_values), 32'h0300_FF80);

    // Restart from DONE with inputs changed after accept: latched values win
    run_op("hold", 32'h0100_0200, 32'h7F00_7F00, 32'h0300_FF80, 0);

    // Saturation both ways
    load_mem(16'h0200, 16'h0200, 16'h0000, 16'hFE00, 16'hFE00, 16'h0000);
    run_op("sat", 32'h7F00_7F00, 32'h7F00_7F00, 32'h7FFF_8000, 0);

    // Truncation toward minus infinity
    load_mem(16'h0080, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000);
    run_op("trunc_neg", 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 0);
    run_op("trunc_pos", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0);

    // Reset mid-operation, then a full clean run
    load_mem(16'h0100, 16'h0100, 16'h0000, 16'h0080, 16'hFF00, 16'h0100);
    run_op("midrst", 32'h0100_0200, 32'h0100_0200, 32'h0300_FF80, 4);
    chk("midrst_idle_valid", 32'(valid), 32'd0);
    run_op("after_rst", 32'h0100_0200, 32'h0100_0200, 32'h0300_FF80, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_output_layer.md
Name: fc_output_layer

Overview:
- Sequential final fully-connected layer of the classifier.
- Computes LAYER_SZ neuron outputs from IN_SZ signed Q8.8 inputs, one multiply-accumulate per cycle, with weights and biases read from an external synchronous weight memory.
- Presents the packed result vector, held stable, directly to the downstream combinational softmax/argmax stage, which produces the class index.

Parameters:
SIZE, 16, data width; signed fixed point, 8 fractional bits (Q8.8)
IN_SZ, 4, number of input activations
LAYER_SZ, 2, number of output neurons (classes)
ADDR_W, 8, weight memory address width; must satisfy 2^ADDR_W >= LAYER_SZ*(IN_SZ+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request computation; sampled only in IDLE or DONE
in_values  in  IN_SZ*SIZE  packed signed inputs, element 0 in the MS slice; sampled on the accepting edge only
w_en  out  1  weight memory read enable
w_addr  out  ADDR_W  weight memory read address
w_data  in  SIZE  signed weight/bias; valid the cycle after w_en/w_addr are presented
out_values  out  LAYER_SZ*SIZE  packed signed Q8.8 results, neuron 0 in the MS slice (matches softmax `values` ordering)
valid  out  1  out_values complete and stable
busy  out  1  computation in progress

Behaviour:
- Reset (rst_n low at a rising edge): state IDLE; valid=0, busy=0, w_en=0, w_addr=0, out_values=0, accumulator and counters cleared. Reset mid-computation aborts immediately; no partial result is written.
- Memory map: neuron n uses addresses n*(IN_SZ+1)+i for weight i (0..IN_SZ-1) and n*(IN_SZ+1)+IN_SZ for its bias. Addresses run linearly 0..N-1, where N = LAYER_SZ*(IN_SZ+1).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE with start=1: latch in_values, set w_en=1 and w_addr=0, busy=1, valid=0; go to RUN.
  - RUN: w_addr increments by 1 each cycle. After address N-1 has been presented, w_en drops to 0 and the FSM goes to DRAIN.
  - DRAIN: the last datum is accumulated and the last neuron is written; then valid=1, busy=0, go to DONE.
  - DONE: hold out_values and valid until the next accepted start or reset.
- Latency: valid rises exactly N+2 rising edges after the accepting edge. Example: IN_SZ=2, LAYER_SZ=2 gives N=6 and valid on edge 8.
- start is ignored while busy=1. A start in DONE restarts the computation and clears valid on the accepting edge.
- Datapath:
  - Accumulator width is 2*SIZE+$clog2(IN_SZ+1)+1, signed. It is cleared at each neuron boundary.
  - For a weight datum: acc += in_values[i] * w_data, a full-precision Q16.16 product.
  - For a bias datum: acc += sign-extended w_data << 8. The neuron then completes.
  - Completion: r = acc >>> 8 (arithmetic shift, truncation toward minus infinity). Saturate r to [0x8000, 0x7FFF] for SIZE=16, i.e. signed SIZE-bit limits. Write r to the out_values slice of that neuron.
- A neuron slice is written on the edge after its bias is accumulated. Slices of an in-progress computation are not guaranteed stable until valid=1; the consumer samples only when valid=1.
- in_values changing after the accepting edge has no effect on the current computation.

Test Plan:
- Basic, IN_SZ=2, LAYER_SZ=2, in_values={0x0100, 0x0200}, memory={0x0100, 0x0100, 0x0000, 0x0080, 0xFF00, 0x0100} -> out_values={0x0300, 0xFF80}, valid high on edge 8 after accept, busy high edges 1-7. Downstream softmax yields class 0.
- Saturation: in_values={0x7F00, 0x7F00}, neuron0 weights 0x0200 with bias 0 -> 0x7FFF. Neuron1 weights 0xFE00 with bias 0 -> 0x8000.
- Truncation: in_values={0xFFFF, 0x0000}, neuron0 weights {0x0080, 0x0000}, bias 0 -> 0xFFFF. in_values={0x0001, 0x0000}, same weights -> 0x0000.
- Handshake: start pulsed again on edges 3 and 5 while busy -> ignored, result unchanged. start in DONE -> valid drops on the accept edge, new result appears N+2 edges later. w_addr sequence 0..5 with w_en high exactly 6 cycles.
- Reset mid-op: rst_n low at edge 4 -> on that edge valid=0, busy=0, w_en=0, out_values=0. A subsequent start produces the correct result with full latency.
- Input hold: in_values changed on edge 2 after accept -> result reflects the values latched at accept.
